// File: rtl/frv_mem_responder.sv
// Single-port word memory answering a req/gnt handshake after a fixed number of wait states.
// Optional macro FRV_MEM_RESPONDER_RAND_STALL_EN replaces the fixed wait count with an LFSR-driven one.
`timescale 1ns/1ps

module frv_mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        mem_wen,
   input  logic [3:0]  mem_strb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic        mem_gnt,
   output logic        mem_error,
   output logic [31:0] mem_rdata,
   output logic        prot_err,
   output logic        busy
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [3:0]  wait_cnt;
   logic        capture;
   logic        prot_set;
   logic        gnt_raw;

   logic [31:0] cap_addr;
   logic        cap_wen;
   logic [3:0]  cap_strb;
   logic [31:0] cap_wdata;

   logic [31:0] mem [DEPTH];

   logic [31:0]           offset;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  mismatch;

`ifdef FRV_MEM_RESPONDER_RAND_STALL_EN
   logic [7:0] lfsr;

   // Fibonacci taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
   always_ff @(posedge clock) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign wait_cnt = {2'b00, lfsr[1:0]};
`else
   assign wait_cnt = 4'(WAIT_CYCLES);
`endif

   // Decode uses the captured request so the result cannot drift with the bus.
   assign offset   = cap_addr - BASE_ADDR;
   assign in_range = (cap_addr >= BASE_ADDR) &&
                     ({1'b0, offset} < (33'd4 << DEPTH_LOG2)) &&
                     (cap_addr[1:0] == 2'b00);
   assign word_idx = offset[DEPTH_LOG2+1:2];

   assign mismatch = (mem_addr != cap_addr) || (mem_wen != cap_wen) ||
                     (mem_strb != cap_strb) || (mem_wdata != cap_wdata);

   // NOTE: every signal driven here gets a default first, otherwise paths that skip an assignment infer latches.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      prot_set  = 1'b0;
      gnt_raw   = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_req) begin
               capture   = 1'b1;
               cnt_nxt   = wait_cnt;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!mem_req || mismatch) begin
               prot_set  = 1'b1;
               cnt_nxt   = 4'd0;
               state_nxt = S_IDLE;
            end else if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               gnt_raw   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         prot_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         prot_err <= prot_err | prot_set;
      end
   end

   always_ff @(posedge clock) begin
      if (capture) begin
         cap_addr  <= mem_addr;
         cap_wen   <= mem_wen;
         cap_strb  <= mem_strb;
         cap_wdata <= mem_wdata;
      end
   end

   assign mem_gnt   = gnt_raw && !reset;
   assign mem_error = mem_gnt && !in_range;
   assign mem_rdata = (mem_gnt && in_range && !cap_wen) ? mem[word_idx] : 32'd0;
   assign busy      = (state == S_WAIT) && !reset;

   // NOTE: the memory array has no reset branch, so its contents survive reset and it maps onto RAM.
   always_ff @(posedge clock) begin
      if (mem_gnt && cap_wen && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (cap_strb[b]) mem[word_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/frv_mem_responder.md
FRV_MEM_RESPONDER -- requirements
Module: frv_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, number of 32-bit words as log2.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, range 0-15, fixed wait states before grant.
REQ-004 The block SHALL have these ports:
  clock      in   1   clock, all state changes on posedge.
  reset      in   1   reset, synchronous, active-high.
  mem_req    in   1   request; held high until granted.
  mem_wen    in   1   1 = write, 0 = read.
  mem_strb   in   4   byte write strobes; ignored for reads.
  mem_wdata  in   32  write data.
  mem_addr   in   32  byte address.
  mem_gnt    out  1   request accepted and completed this cycle.
  mem_error  out  1   access faulted; valid only while mem_gnt=1.
  mem_rdata  out  32  read data; valid only while mem_gnt=1.
  prot_err   out  1   sticky flag for a requester protocol violation.
  busy       out  1   1 while state is not IDLE.

Function
REQ-005 The block SHALL have a state machine with states IDLE and WAIT, plus a 4-bit wait counter cnt.
REQ-006 In IDLE with mem_req=1, the block SHALL capture addr/wen/strb/wdata, load cnt with the wait count, and enter WAIT; mem_gnt SHALL be 0 in IDLE.
REQ-007 In WAIT with cnt!=0, the block SHALL decrement cnt and hold mem_gnt=0.
REQ-008 In WAIT with cnt==0 and mem_req=1, the block SHALL assert mem_gnt combinationally, complete the access on that clock edge, and return to IDLE.
REQ-009 Latency SHALL be wait count + 1 cycles from the first cycle mem_req is high to the mem_gnt cycle; back-to-back requests SHALL see at least one IDLE cycle between grants.
REQ-010 An access SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2 and addr[1:0]==0.
REQ-011 An out-of-range or misaligned access SHALL complete with mem_error=1 and mem_rdata=0, and SHALL leave memory unmodified.
REQ-012 A read SHALL return the word at index (addr-BASE_ADDR)>>2 on mem_rdata in the grant cycle.
REQ-013 A write SHALL update only the byte lanes whose mem_strb bit is 1, and mem_rdata SHALL be 0 in the grant cycle.
REQ-014 A write with mem_strb=0 SHALL be granted without error and without modifying memory.
REQ-015 If, in WAIT, mem_req drops or any of addr/wen/strb/wdata differs from the captured value, the block SHALL set prot_err, return to IDLE with no grant and no write, and keep prot_err set until reset.
REQ-016 Whenever mem_gnt=0, mem_error and mem_rdata SHALL be driven 0.
REQ-017 The result of a read SHALL be derived from the captured address; a write SHALL use the captured strb/wdata.

Reset
REQ-018 While reset=1 the block SHALL force state to IDLE, cnt=0, prot_err=0, mem_gnt=0, mem_error=0, mem_rdata=0, busy=0.
REQ-019 Reset asserted during WAIT SHALL abort the transaction with no write and no grant.
REQ-020 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-021 With macro FRV_MEM_RESPONDER_RAND_STALL_EN defined, the block SHALL contain an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
REQ-022 With that macro defined, the LFSR SHALL be seeded to 8'hA5 on reset and SHALL advance every cycle.
REQ-023 With that macro defined, the wait count SHALL be lfsr[1:0], sampled on the IDLE->WAIT transition.
REQ-024 Without FRV_MEM_RESPONDER_RAND_STALL_EN, the wait count SHALL be WAIT_CYCLES and no LFSR logic SHALL exist.

Verification
REQ-025 Write 32'hDEADBEEF to 0x10 with strb=4'hF, then read 0x10 -> read grant has rdata=32'hDEADBEEF, error=0; each grant occurs 3 cycles after req rises (WAIT_CYCLES=2).
REQ-026 After REQ-025, write 32'h11223344 to 0x10 with strb=4'b0101, then read 0x10 -> rdata=32'hDE22BE44.
REQ-027 Read 0x0000_0400 (DEPTH_LOG2=8) and read 0x12 -> each grant has error=1, rdata=0; memory is unchanged.
REQ-028 Drop mem_req one cycle after the IDLE->WAIT transition -> no grant, prot_err=1 and held until reset, then prot_err=0 after reset.
REQ-029 Assert reset mid-WAIT on a write to 0x20 -> no grant; a subsequent read of 0x20 returns the pre-write value.
REQ-030 With FRV_MEM_RESPONDER_RAND_STALL_EN defined, issue 16 back-to-back reads -> every grant latency is in 1-4 cycles, and the latency sequence is identical across two runs from reset.
